// File: rtl/sccb_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sccb_init_sequencer_if
// Brief    : Init-ROM read port and SCCB byte-engine handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sccb_init_sequencer_if #(
  parameter int ROM_AW = 8
);
  logic [ROM_AW-1:0] o_rom_addr;
  logic [23:0]       i_rom_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              o_tx_stop;
  logic              i_tx_ready;
  logic              i_ack;

  modport master (
    output o_rom_addr, o_tx_data, o_tx_start, o_tx_stop,
    input  i_rom_data, i_tx_ready, i_ack
  );

  modport slave (
    input  o_rom_addr, o_tx_data, o_tx_start, o_tx_stop,
    output i_rom_data, i_tx_ready, i_ack
  );
endinterface
`default_nettype wire

// File: rtl/sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sccb_init_sequencer
// Brief    : Walks an OV5642 register-init ROM and feeds the SCCB byte engine.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_init_sequencer #(
  parameter logic [7:0]  DEV_ID    = 8'h78,
  parameter int          ROM_AW    = 8,
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned MS_CYCLES = CLK_FREQ / 1000
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ROM_AW-1:0]      o_entry_cnt,
  sccb_init_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_ARM       = 4'd3,
    S_XFER      = 4'd4,
    S_WAIT_IDLE = 4'd5,
    S_DELAY     = 4'd6,
    S_NEXT      = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              tx_stop_q;
  logic [ROM_AW-1:0] entry_cnt_q;
  logic [1:0]        idx_q;
  logic [31:0]       dly_q;
  logic [23:0]       entry_q;
  logic              skip_q;

  logic        w_is_end;
  logic        w_is_dly;
  logic [31:0] w_dly_cycles;
  logic [1:0]  w_next_idx;
  logic [7:0]  w_next_byte;

  assign w_is_end     = (bus.i_rom_data[23:8] == 16'hFFFF);
  assign w_is_dly     = (bus.i_rom_data[23:8] == 16'hFFFE);
  assign w_dly_cycles = {24'd0, bus.i_rom_data[7:0]} * MS_CYCLES;
  assign w_next_idx   = idx_q + 2'd1;

  always_comb begin
    w_next_byte = DEV_ID;
    case (w_next_idx)
      2'd0:    w_next_byte = DEV_ID;
      2'd1:    w_next_byte = entry_q[23:16];
      2'd2:    w_next_byte = entry_q[15:8];
      default: w_next_byte = entry_q[7:0];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_addr_q  <= '0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      tx_stop_q   <= 1'b0;
      entry_cnt_q <= '0;
      idx_q       <= 2'd0;
      dly_q       <= 32'd0;
      entry_q     <= 24'd0;
      skip_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q     <= S_FETCH;
            rom_addr_q  <= '0;
            entry_cnt_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          entry_q <= bus.i_rom_data;
          if (w_is_end) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            tx_stop_q <= 1'b0;
          end else if (w_is_dly) begin
            // A zero-length delay skips the DELAY state entirely.
            if (bus.i_rom_data[7:0] == 8'd0) begin
              state_q <= S_NEXT;
            end else begin
              dly_q   <= w_dly_cycles;
              state_q <= S_DELAY;
            end
          end else begin
            tx_data_q <= DEV_ID;
            idx_q     <= 2'd0;
            state_q   <= S_ARM;
          end
        end
        S_ARM: begin
          if (bus.i_tx_ready) begin
            tx_start_q <= 1'b1;
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (bus.i_ack) begin
            if (idx_q == 2'd3) begin
              state_q     <= S_WAIT_IDLE;
              entry_cnt_q <= entry_cnt_q + ROM_AW'(1);
              tx_stop_q   <= 1'b0;
              skip_q      <= 1'b1;
            end else begin
              idx_q     <= w_next_idx;
              tx_data_q <= w_next_byte;
              tx_stop_q <= (w_next_idx == 2'd3);
            end
          end
        end
        S_WAIT_IDLE: begin
          // Engine still reports ready during the first cycle of its stop phase.
          skip_q <= 1'b0;
          if (!skip_q && bus.i_tx_ready) begin
            state_q <= S_NEXT;
          end
        end
        S_DELAY: begin
          if (dly_q <= 32'd1) begin
            dly_q   <= 32'd0;
            state_q <= S_NEXT;
          end else begin
            dly_q <= dly_q - 32'd1;
          end
        end
        S_NEXT: begin
          if (&rom_addr_q) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            tx_stop_q <= 1'b0;
          end else begin
            rom_addr_q <= rom_addr_q + ROM_AW'(1);
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_entry_cnt    = entry_cnt_q;
  assign bus.o_rom_addr = rom_addr_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_stop  = tx_stop_q;

endmodule
`default_nettype wire
